potential_accumulator: RTL
==========================

# potential_accumulator

Integrates incoming IEEE-754 single-precision synaptic weight contributions into a neuron's membrane potential over one timestep. Sits upstream of `potential_decay`, and its `potential_out` feeds that block's `input_potential`. A weight stream arrives over a valid/ready handshake. On each timestep boundary (`clear`), the accumulated potential is published and the accumulator reloads.

## Interface
- `INIT_POTENTIAL`, default `32'h00000000`: float32 value loaded into the accumulator on reset and on every `clear`.
- `CLK` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clear` input 1: timestep boundary strobe; publishes the sum and reloads the accumulator.
- `weight_in` input 32: float32 weight contribution.
- `weight_valid` input 1: `weight_in` is valid.
- `weight_ready` output 1: block can accept a weight this cycle.
- `potential_out` output 32: published potential, held stable between publishes.
- `potential_valid` output 1: one-cycle pulse when `potential_out` updates.
- `busy` output 1: an addition is in flight.
- `ovf` output 1: sticky overflow flag; present only with `POTENTIAL_ACCUM_OVF_FLAG_EN`.

## Operation
- The FSM has four states: IDLE, ALIGN, ADD, NORM.
  - IDLE → ALIGN on handshake (`weight_valid & weight_ready`). The weight is captured in this transition.
  - ALIGN → ADD → NORM → IDLE unconditionally.
- `weight_ready` = (state==IDLE) & !`clear` & !clear_pending.
- `busy` = (state!=IDLE).
- ALIGN stage:
  - Unpack both operands and restore the hidden 1.
  - Swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference. A difference ≥ 25 contributes 0.
- ADD stage: add mantissas if the signs match, otherwise subtract the smaller from the larger. Result sign is the sign of the larger operand.
- NORM stage:
  - Renormalize via carry-out right shift or leading-zero left shift.
  - Round toward zero (truncate).
  - Write the accumulator.
- Arithmetic rules:
  - Denormal inputs and results flush to +0.
  - An exact zero result is +0.
  - An exponent of 255 on input, or exponent overflow on output, saturates to ±`0x7F7FFFFF`.
  - NaN and Inf are never produced.
- `clear` sampled in IDLE:
  - Next cycle, `potential_out` ← accumulator and `potential_valid`=1.
  - The accumulator reloads to `INIT_POTENTIAL` in the same edge.
- `clear` sampled while busy:
  - Sets clear_pending.
  - The in-flight add completes and is included in the sum.
  - The publish happens on the edge that leaves NORM, so `potential_valid` is high in the first IDLE cycle.
  - clear_pending is then cleared.
- `clear` and `weight_valid` in the same IDLE cycle: `clear` wins and the weight is not accepted (`weight_ready`=0).
- Back-to-back `clear` pulses: each one publishes. The second publishes `INIT_POTENTIAL`.

## Timing
- Reset values:
  - state IDLE; accumulator = `INIT_POTENTIAL`.
  - `potential_out`=0, `potential_valid`=0, `busy`=0, clear_pending=0, `ovf`=0.
  - `weight_ready` is 1 from the cycle after reset deasserts.
- Reset asserted mid-operation aborts the in-flight add and discards clear_pending.
- Accept-to-accumulate latency is 3 cycles; the accumulator is updated on the NORM edge.
- Throughput is one weight per 4 cycles. `weight_ready` is low for 3 cycles after each accept.
- Publish latency:
  - 1 cycle from `clear` sampled in IDLE.
  - Otherwise at the NORM-exit edge.
- `potential_out` holds its value until the next publish. `potential_valid` is never high for two consecutive cycles unless `clear` is high for two IDLE cycles.

## Configuration
- `POTENTIAL_ACCUM_OVF_FLAG_EN` defined:
  - Port `ovf` exists.
  - It is set on any saturating result in NORM and on any exponent-255 input.
  - It is sticky until `reset`; `clear` does not clear it.
- `POTENTIAL_ACCUM_OVF_FLAG_EN` undefined: no `ovf` port or logic. Saturation behaviour is unchanged.

## Test plan
- Two weights, publish: with INIT=0, send 10.0 (`0x41200000`) then 2.5 (`0x40200000`), then `clear` → `potential_out`=`0x41480000` (12.5) with a 1-cycle `potential_valid`. A second `clear` → `0x00000000`.
- Cancellation: send 1.0 (`0x3F800000`) and −1.0 (`0xBF800000`), then `clear` → `0x00000000`.
- Saturation: send `0x7F7FFFFF` twice, then `clear` → `0x7F7FFFFF`; `ovf`=1 with the macro, and it stays 1 after `clear`.
- Clear while busy: accept 10.0 at cycle t and pulse `clear` at t+1 → `potential_valid` at t+4 with `0x41200000`. `weight_ready` stays 0 through t+4.
- Handshake and priority:
  - Hold `weight_valid` continuously → one accept every 4 cycles.
  - `clear` plus `weight_valid` in IDLE → weight not accepted and no change to the next sum.
- Reset mid-add: accept 10.0, assert `reset` at the ADD cycle, then `clear` → `potential_out`=`0x00000000`.

Source files
------------

// File: rtl/potential_accumulator_if.sv
// potential_accumulator_if: weight stream, clear strobe and publish bus for potential_accumulator.
// The ovf wire and its modport entries exist only with POTENTIAL_ACCUM_OVF_FLAG_EN.
interface potential_accumulator_if;
    logic        clear;
    logic [31:0] weight_in;
    logic        weight_valid;
    logic        weight_ready;
    logic [31:0] potential_out;
    logic        potential_valid;
    logic        busy;
`ifdef POTENTIAL_ACCUM_OVF_FLAG_EN
    logic        ovf;
    modport master (
        output clear, weight_in, weight_valid,
        input  weight_ready, potential_out, potential_valid, busy, ovf
    );
    modport slave (
        input  clear, weight_in, weight_valid,
        output weight_ready, potential_out, potential_valid, busy, ovf
    );
`else
    modport master (
        output clear, weight_in, weight_valid,
        input  weight_ready, potential_out, potential_valid, busy
    );
    modport slave (
        input  clear, weight_in, weight_valid,
        output weight_ready, potential_out, potential_valid, busy
    );
`endif
endinterface

// File: rtl/potential_accumulator.sv
// potential_accumulator: float32 membrane integrator, truncating ALIGN/ADD/NORM adder, publishes on clear.
// Optional sticky ovf flag enabled by POTENTIAL_ACCUM_OVF_FLAG_EN.
module potential_accumulator #(
    parameter logic [31:0] INIT_POTENTIAL = 32'h00000000
) (
    input logic CLK,
    input logic reset,
    potential_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;
    state_t state, state_nx;
    logic [31:0] acc, w_q;
    logic clear_pending, accept, publish;
    logic r_sign, r_sat, r_sub;
    logic [7:0] r_exp;
    logic [23:0] r_big, r_small;
    logic [24:0] r_sum;
    logic a_first, l_sign, s_sign;
    logic [30:0] a_key, w_key;
    logic [7:0] ea, ew, l_exp, s_exp, diff;
    logic [23:0] ma, mw, l_mant, s_mant;
    logic [4:0] lz;
    logic signed [9:0] n_exp;
    logic [22:0] n_frac;
    logic n_sat, n_zero;
    logic [31:0] n_res;

    function automatic logic [4:0] lead_zeros(input logic [23:0] m);
        lead_zeros = 5'd0;
        for (int i = 0; i < 24; i++)
            if (m[i]) lead_zeros = 5'(23 - i);
    endfunction

    assign bus.weight_ready = (state == IDLE) & !bus.clear & !clear_pending;
    assign bus.busy = (state != IDLE);
    assign accept = bus.weight_valid & bus.weight_ready;
    assign publish = (state == IDLE) ? bus.clear : (state == NORM) & (clear_pending | bus.clear);

    always_comb begin
        state_nx = (state == IDLE) ? (accept ? ALIGN : IDLE) :
                   (state == ALIGN) ? ADD :
                   (state == ADD) ? NORM : IDLE;
    end

    // Denormals unpack as magnitude zero so they drop out of the ordering and the sum.
    always_comb begin
        ea = acc[30:23];
        ew = w_q[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, acc[22:0]};
        mw = (ew == 8'd0) ? 24'd0 : {1'b1, w_q[22:0]};
        a_key = (ea == 8'd0) ? 31'd0 : acc[30:0];
        w_key = (ew == 8'd0) ? 31'd0 : w_q[30:0];
        a_first = a_key >= w_key;
        l_sign = a_first ? acc[31] : w_q[31];
        s_sign = a_first ? w_q[31] : acc[31];
        l_exp = a_first ? ea : ew;
        s_exp = a_first ? ew : ea;
        l_mant = a_first ? ma : mw;
        s_mant = a_first ? mw : ma;
        diff = l_exp - s_exp;
    end

    always_comb begin
        lz = lead_zeros(r_sum[23:0]);
        n_exp = r_sum[24] ? $signed({2'b00, r_exp}) + 10'sd1
                          : $signed({2'b00, r_exp}) - $signed({5'b00000, lz});
        n_frac = r_sum[24] ? r_sum[23:1] : r_sum[22:0] << lz;
        n_sat = r_sat | (n_exp >= 10'sd255);
        n_zero = (r_sum == 25'd0) | (n_exp <= 10'sd0);
        n_res = n_sat ? {r_sign, 31'h7F7FFFFF} : n_zero ? 32'd0 : {r_sign, n_exp[7:0], n_frac};
    end

    always_ff @(posedge CLK) state <= reset ? IDLE : state_nx;

    always_ff @(posedge CLK) begin
        if (reset) begin
            acc <= INIT_POTENTIAL;
            w_q <= 32'd0;
            clear_pending <= 1'b0;
            bus.potential_out <= 32'd0;
            bus.potential_valid <= 1'b0;
            r_sign <= 1'b0;
            r_sat <= 1'b0;
            r_sub <= 1'b0;
            r_exp <= 8'd0;
            r_big <= 24'd0;
            r_small <= 24'd0;
            r_sum <= 25'd0;
        end else begin
            bus.potential_valid <= publish;
            clear_pending <= (state != IDLE) & (clear_pending | bus.clear);
            if (accept) w_q <= bus.weight_in;
            if (state == ALIGN) begin
                r_sign <= l_sign;
                r_exp <= l_exp;
                r_sat <= (ea == 8'hFF) | (ew == 8'hFF);
                r_sub <= l_sign ^ s_sign;
                r_big <= l_mant;
                r_small <= (diff >= 8'd25) ? 24'd0 : s_mant >> diff;
            end
            if (state == ADD)
                r_sum <= r_sub ? {1'b0, r_big} - {1'b0, r_small} : {1'b0, r_big} + {1'b0, r_small};
            if (publish) acc <= INIT_POTENTIAL;
            else if (state == NORM) acc <= n_res;
            if (publish) bus.potential_out <= (state == NORM) ? n_res : acc;
        end
    end

`ifdef POTENTIAL_ACCUM_OVF_FLAG_EN
    always_ff @(posedge CLK)
        bus.ovf <= !reset & (bus.ovf | ((state == NORM) & n_sat) | (accept & (&bus.weight_in[30:23])));
`endif
endmodule
